// File: rtl/uart_axil_pkg.sv
// Shared types for the UART AXI4-Lite slave front end.
// Response codes, FSM state encodings and register-range constants.
package uart_axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_EXEC,
        R_RESP
    } rd_state_t;

    // Byte-offset bits below the register word index.
    localparam int WORD_LSB = 2;

endpackage

// File: rtl/uart_axil_slave.sv
// AXI4-Lite slave driving the UART register file with one strobe per transaction.
// Define UART_AXIL_SLVERR_EN to report decode errors and reg_error as SLVERR.
module uart_axil_slave
    import uart_axil_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [DATA_WIDTH-1:0]       s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]       s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [DATA_WIDTH-1:0]       s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    output logic [REG_ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]       reg_wdata,
    output logic [DATA_WIDTH/8-1:0]     reg_wstrb,
    output logic                        reg_wen,
    output logic                        reg_ren,
    input  logic [DATA_WIDTH-1:0]       reg_rdata,
    input  logic                        reg_error
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int HI     = REG_ADDR_WIDTH + WORD_LSB;

    wr_state_t               wst_q, wst_d;
    rd_state_t               rst_q, rst_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    axil_resp_t              bresp_q, bresp_d;
    axil_resp_t              rresp_q, rresp_d;
    logic                    last_rd_q, last_rd_d;

    logic w_req, r_req, w_gnt, r_gnt;
    logic w_err, r_err, w_slv, r_slv;

    function automatic logic dec_err(input logic [ADDR_WIDTH-1:0] a);
        return (a[WORD_LSB-1:0] != '0) || ((a >> HI) != '0);
    endfunction

    // last_rd_q only moves on real contention, so winners alternate.
    assign w_req = (wst_q == W_EXEC);
    assign r_req = (rst_q == R_EXEC);
    assign r_gnt = r_req && (!w_req || !last_rd_q);
    assign w_gnt = w_req && !r_gnt;
    assign w_err = dec_err(awaddr_q);
    assign r_err = dec_err(araddr_q);

`ifdef UART_AXIL_SLVERR_EN
    assign w_slv = w_err;
    assign r_slv = r_err || reg_error;
`else
    logic unused_reg_error;
    assign unused_reg_error = reg_error;
    assign w_slv = 1'b0;
    assign r_slv = 1'b0;
`endif

    assign reg_wen   = w_gnt && !w_err;
    assign reg_ren   = r_gnt && !r_err;
    assign reg_addr  = r_gnt ? araddr_q[HI-1:WORD_LSB]
                             : awaddr_q[HI-1:WORD_LSB];
    assign reg_wdata = wdata_q;
    assign reg_wstrb = wstrb_q;

    assign s_axil_awready = (wst_q == W_IDLE) && !aw_done_q;
    assign s_axil_wready  = (wst_q == W_IDLE) && !w_done_q;
    assign s_axil_bvalid  = (wst_q == W_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = (rst_q == R_IDLE);
    assign s_axil_rvalid  = (rst_q == R_RESP);
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

    always_comb begin
        wst_d     = wst_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        unique case (wst_q)
            W_IDLE: begin
                if (s_axil_awvalid && !aw_done_q) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = s_axil_awaddr;
                end
                if (s_axil_wvalid && !w_done_q) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_axil_wdata;
                    wstrb_d  = s_axil_wstrb;
                end
                if (aw_done_d && w_done_d) begin
                    wst_d     = W_EXEC;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_EXEC: begin
                if (w_gnt) begin
                    wst_d   = W_RESP;
                    bresp_d = w_slv ? SLVERR : OKAY;
                end
            end
            W_RESP: begin
                if (s_axil_bready) wst_d = W_IDLE;
            end
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        rst_d     = rst_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        last_rd_d = last_rd_q;
        if (w_req && r_req) last_rd_d = r_gnt;
        unique case (rst_q)
            R_IDLE: begin
                if (s_axil_arvalid) begin
                    rst_d    = R_EXEC;
                    araddr_d = s_axil_araddr;
                end
            end
            R_EXEC: begin
                if (r_gnt) begin
                    rst_d   = R_RESP;
                    rdata_d = r_err ? '0 : reg_rdata;
                    rresp_d = r_slv ? SLVERR : OKAY;
                end
            end
            R_RESP: begin
                if (s_axil_rready) rst_d = R_IDLE;
            end
            default: rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q     <= W_IDLE;
            rst_q     <= R_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            last_rd_q <= 1'b0;
        end else begin
            wst_q     <= wst_d;
            rst_q     <= rst_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            last_rd_q <= last_rd_d;
        end
    end

endmodule

// File: doc/uart_axil_slave.md
# uart_axil_slave

AXI4-Lite slave front end for the UART peripheral. Terminates the CPU-side AXI4-Lite bus and drives the UART register file's simple register interface (`reg_addr`/`reg_wen`/`reg_ren`/`reg_rdata`/`reg_error`). It issues exactly one single-cycle register access per AXI transaction, which makes read side effects (RX_DATA pop) safe. It sits between the SoC interconnect and the register file.

## Interface
- `DATA_WIDTH`, default 32: AXI and register data width.
- `ADDR_WIDTH`, default 8: AXI byte address width.
- `REG_ADDR_WIDTH`, default 4: register word-index width.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_axil_awaddr` in ADDR_WIDTH / `s_axil_awvalid` in 1 / `s_axil_awready` out 1: write address channel.
- `s_axil_wdata` in DATA_WIDTH / `s_axil_wstrb` in DATA_WIDTH/8 / `s_axil_wvalid` in 1 / `s_axil_wready` out 1: write data channel.
- `s_axil_bresp` out 2 / `s_axil_bvalid` out 1 / `s_axil_bready` in 1: write response channel.
- `s_axil_araddr` in ADDR_WIDTH / `s_axil_arvalid` in 1 / `s_axil_arready` out 1: read address channel.
- `s_axil_rdata` out DATA_WIDTH / `s_axil_rresp` out 2 / `s_axil_rvalid` out 1 / `s_axil_rready` in 1: read data channel.
- `reg_addr` out REG_ADDR_WIDTH: word index, `addr[REG_ADDR_WIDTH+1:2]`.
- `reg_wdata` out DATA_WIDTH / `reg_wstrb` out DATA_WIDTH/8: latched write data and strobes.
- `reg_wen` out 1 / `reg_ren` out 1: single-cycle access strobes.
- `reg_rdata` in DATA_WIDTH / `reg_error` in 1: combinational read result, valid in the `reg_ren` cycle.

## Operation
- **Write FSM:** `W_IDLE` → `W_EXEC` → `W_RESP`.
  - In `W_IDLE`, AW and W are accepted independently, each latched once.
  - `awready` = idle && AW not latched; `wready` = idle && W not latched.
  - When both are latched, go to `W_EXEC`.
- **Read FSM:** `R_IDLE` → `R_EXEC` → `R_RESP`. `arready` = (state == `R_IDLE`). Address is latched on handshake.
- **Arbitration:** at most one of `reg_wen` and `reg_ren` is high per cycle. An EXEC state waits for grant. If both are in EXEC, grant goes to the channel not granted last; after reset, read has priority.
- **Granted write EXEC:** if there is no decode error, pulse `reg_wen` for one cycle with `reg_addr`, `reg_wdata`, and `reg_wstrb` from the latches. Then go to `W_RESP` with `bvalid`=1.
- **Granted read EXEC:** if there is no decode error, pulse `reg_ren` for one cycle. In the same edge, capture `reg_rdata` into `rdata` and set `rresp`. Then go to `R_RESP` with `rvalid`=1.
- **RESP states:** hold `valid` and payload stable until `ready`, then return to IDLE.
- **Decode error:** `addr[1:0]` ≠ 0, or any address bit above `REG_ADDR_WIDTH+1` set.
  - No strobe is issued.
  - The response is SLVERR (see Configuration), and `rdata` = 0.
- Read `rresp` = SLVERR when there is a decode error or `reg_error` is high in the `reg_ren` cycle.
- Write `bresp` = SLVERR on decode error, otherwise OKAY.
- Both outstanding limits are 1; no new address is accepted until the response handshake completes.

## Timing
- Reset values:
  - `awready`, `wready`, `arready` = 1.
  - `bvalid`, `rvalid`, `reg_wen`, `reg_ren` = 0.
  - `bresp`, `rresp` = 2'b00; `rdata`, `reg_wdata`, `reg_wstrb`, `reg_addr` = 0.
- Write with AW and W both handshaken at cycle 0: `reg_wen` at cycle 1, `bvalid` at cycle 2.
  - If W arrives k cycles after AW, the sequence shifts by k.
- Read handshake at cycle 0: `reg_ren` at cycle 1, `rvalid` at cycle 2. Read data is registered, so it is stable while `rvalid` is held.
- With `bready`/`rready` held high, the response lasts 1 cycle, giving back-to-back throughput of one transaction per 3 cycles per channel.
- A write and a read contending for EXEC in the same cycle delays the loser by exactly 1 cycle.
- `reg_wen`/`reg_ren` are never high for more than 1 cycle per transaction, including under `ready` backpressure.
- Reset asserted mid-transaction: all FSMs return to IDLE immediately, pending responses are dropped, and no strobe is emitted.

## Configuration
- `UART_AXIL_SLVERR_EN` defined: decode errors and `reg_error` produce SLVERR (2'b10).
- Undefined: all responses are OKAY. Decode-error reads return 0 and decode-error writes are dropped silently; still no strobe is issued.

## Structure
- Package `uart_axil_pkg`:
  - `axil_resp_t` (OKAY=2'b00, SLVERR=2'b10).
  - `wr_state_t`, `rd_state_t` enums.
  - Localparams for the register-range check.
- Single module; the arbiter is a one-bit last-grant flop inline. No sub-module.

## Test plan
- **Write:** AW=0x00, W=0x3, strb=0x1 same cycle → `reg_wen` for 1 cycle at cycle 1, `reg_addr`=0, `reg_wdata`=0x3; `bvalid` at cycle 2, `bresp`=OKAY.
- **Split write:** W at cycle 0, AW=0x10 at cycle 3 → `reg_wen` at cycle 4, `reg_addr`=4.
- **Read:** AR=0x04, `reg_rdata`=0x0003_0201 → `rvalid` at cycle 2, `rdata`=0x0003_0201; `rready` held low 5 cycles → data stable and exactly one `reg_ren` pulse.
- **Decode errors (macro defined):** AR=0x06 or AR=0x40 → no `reg_ren`, `rresp`=2'b10, `rdata`=0. Read with `reg_error`=1 → SLVERR.
- **Contention:** write and read reach EXEC in the same cycle after reset → `reg_ren` first, `reg_wen` next cycle. Repeat → write first.
- **Reset mid-op:** drop `rst_n` while `bvalid`=1 → `bvalid`=0 asynchronously; after release, `awready`/`wready`/`arready`=1 and no strobe.
